// File: rtl/run_before_decoder.sv
// ---------------------------------------------------------------------------
// run_before_decoder
//
// Decodes the run_before syntax elements of one CAVLC residual block. Each
// block carries NZQ non-zero coefficients and total_zeros zeros spread
// between them. Runs are read from a bit FIFO one bit per cycle and reported
// one per cycle on run_before/run_idx, highest-frequency coefficient first.
// Runs that need no bitstream bits are synthesised without touching the FIFO:
//   - all zeros are used up -> the remaining runs are 0
//   - the last coefficient  -> its run is whatever zeros are left
//
// Ports
//   clk, rst          : clock, asynchronous active-low reset
//   start             : one-cycle block request, honoured only while idle
//   NZQ, total_zeros  : block parameters, sampled together with start
//   fifo_data         : head bit of a first-word-fall-through bit FIFO
//   fifo_empty        : FIFO holds no bit
//   fifo_pop          : consume fifo_data at the coming clock edge
//   run_before        : decoded run, qualified by run_valid
//   run_idx           : coefficient index of run_before (0 = highest freq.)
//   run_valid         : one-cycle qualifier for run_before/run_idx
//   busy              : block in progress (any state other than IDLE)
//   finish            : one-cycle pulse at block end
//   error             : one-cycle pulse with finish on an illegal code
//   dbg_state_o       : current FSM state, for debug and checkers
//
// FIFO handshake: a bit moves out of the FIFO at a rising edge exactly when
// fifo_pop is high in the cycle before it. fifo_pop is only ever high while
// fifo_empty is low, so pop and valid data always coincide; while the FIFO
// is empty the decoder simply waits with its partial code held.
// ---------------------------------------------------------------------------
module run_before_decoder #(
  parameter int NZQ_WIDTH = 5,
  parameter int ZL_WIDTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NZQ_WIDTH-1:0] NZQ,
  input  logic [ZL_WIDTH-1:0]  total_zeros,
  input  logic                 fifo_data,
  input  logic                 fifo_empty,
  output logic                 fifo_pop,
  output logic [ZL_WIDTH-1:0]  run_before,
  output logic [NZQ_WIDTH-1:0] run_idx,
  output logic                 run_valid,
  output logic                 busy,
  output logic                 finish,
  output logic                 error,
  output logic [2:0]           dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_READ      = 3'd1,
    S_EMIT_ZERO = 3'd2,
    S_LAST      = 3'd3,
    S_DONE      = 3'd4
  } state_e;

  // Longest legal code is 11 bits, so an 11-bit shift register and a
  // 4-bit length counter hold any partial code.
  localparam int CODE_W = 11;

  state_e                 state_q;
  logic [ZL_WIDTH-1:0]    zeros_left_q;
  logic [NZQ_WIDTH-1:0]   remaining_q;
  logic [NZQ_WIDTH-1:0]   idx_q;
  logic [CODE_W-1:0]      code_q;
  logic [3:0]             len_q;
  logic [ZL_WIDTH-1:0]    run_before_q;
  logic [NZQ_WIDTH-1:0]   run_idx_q;
  logic                   run_valid_q;
  logic                   busy_q;
  logic                   finish_q;
  logic                   error_q;

  // Partial code including the bit currently at the FIFO head.
  logic [CODE_W-1:0]      code_d;
  logic [3:0]             len_d;
  logic [2:0]             zl_sel;
  logic                   dec_hit;
  logic                   dec_bad;
  logic [3:0]             dec_run;
  logic [ZL_WIDTH-1:0]    run_ext;
  logic                   dec_illegal;
  logic [ZL_WIDTH-1:0]    zl_after;
  logic [NZQ_WIDTH-1:0]   rem_after;

  assign code_d    = {code_q[CODE_W-2:0], fifo_data};
  assign len_d     = len_q + 4'd1;
  // Every zeros_left above 6 shares one table.
  assign zl_sel    = (zeros_left_q > ZL_WIDTH'(7)) ? 3'd7 : zeros_left_q[2:0];
  assign run_ext   = ZL_WIDTH'(dec_run);
  // A run longer than the zeros still available can only come from a
  // corrupt stream or an inconsistent total_zeros.
  assign dec_illegal = dec_bad || (dec_hit && (run_ext > zeros_left_q));
  assign zl_after  = zeros_left_q - run_ext;
  assign rem_after = remaining_q - NZQ_WIDTH'(1);

  // Table lookup on the partial code. dec_hit marks a complete code; when
  // neither dec_hit nor dec_bad is set, more bits are needed.
  always_comb begin
    dec_hit = 1'b0;
    dec_bad = 1'b0;
    dec_run = 4'd0;
    case (zl_sel)
      3'd0: begin
        // No bits are read with zero zeros left; nothing to decode.
      end
      3'd1: begin
        dec_hit = 1'b1;
        dec_run = {3'b000, ~code_d[0]};
      end
      3'd2: begin
        if (len_d == 4'd1) begin
          dec_hit = code_d[0];
        end else begin
          dec_hit = 1'b1;
          dec_run = code_d[0] ? 4'd1 : 4'd2;
        end
      end
      3'd3: begin
        if (len_d == 4'd2) begin
          dec_hit = 1'b1;
          dec_run = 4'd3 - {2'b00, code_d[1:0]};
        end
      end
      3'd4: begin
        if ((len_d == 4'd2) && (code_d[1:0] != 2'b00)) begin
          dec_hit = 1'b1;
          dec_run = 4'd3 - {2'b00, code_d[1:0]};
        end else if (len_d == 4'd3) begin
          dec_hit = 1'b1;
          dec_run = code_d[0] ? 4'd3 : 4'd4;
        end
      end
      3'd5: begin
        if ((len_d == 4'd2) && code_d[1]) begin
          dec_hit = 1'b1;
          dec_run = code_d[0] ? 4'd0 : 4'd1;
        end else if (len_d == 4'd3) begin
          dec_hit = 1'b1;
          dec_run = 4'd5 - {1'b0, code_d[2:0]};
        end
      end
      3'd6: begin
        if ((len_d == 4'd2) && (code_d[1:0] == 2'b11)) begin
          dec_hit = 1'b1;
        end else if (len_d == 4'd3) begin
          dec_hit = 1'b1;
          case (code_d[2:0])
            3'b000:  dec_run = 4'd1;
            3'b001:  dec_run = 4'd2;
            3'b011:  dec_run = 4'd3;
            3'b010:  dec_run = 4'd4;
            3'b101:  dec_run = 4'd5;
            3'b100:  dec_run = 4'd6;
            default: dec_run = 4'd0;
          endcase
        end
      end
      default: begin
        // 3-bit codes 111..001 give 0..6; after 000 the code is a unary
        // prefix of zeros closed by a 1, and a code of length L gives L+3.
        if (len_d < 4'd4) begin
          if ((len_d == 4'd3) && (code_d[2:0] != 3'b000)) begin
            dec_hit = 1'b1;
            dec_run = 4'd7 - {1'b0, code_d[2:0]};
          end
        end else if (code_d[0]) begin
          dec_hit = 1'b1;
          dec_run = len_d + 4'd3;
        end else if (len_d == 4'd11) begin
          dec_bad = 1'b1;
        end
      end
    endcase
  end

  // The head bit is consumed whenever the decoder is reading and a bit is
  // available; the register update below uses the same condition.
  assign fifo_pop    = (state_q == S_READ) && !fifo_empty;

  assign run_before  = run_before_q;
  assign run_idx     = run_idx_q;
  assign run_valid   = run_valid_q;
  assign busy        = busy_q;
  assign finish      = finish_q;
  assign error       = error_q;
  assign dbg_state_o = state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      zeros_left_q <= '0;
      remaining_q  <= '0;
      idx_q        <= '0;
      code_q       <= '0;
      len_q        <= '0;
      run_before_q <= '0;
      run_idx_q    <= '0;
      run_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      finish_q     <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      // Pulse outputs default low; each state raises what it needs.
      run_valid_q <= 1'b0;
      finish_q    <= 1'b0;
      error_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            zeros_left_q <= total_zeros;
            remaining_q  <= NZQ;
            idx_q        <= '0;
            code_q       <= '0;
            len_q        <= '0;
            busy_q       <= 1'b1;
            if (NZQ == '0) begin
              state_q <= S_DONE;
            end else if (NZQ == NZQ_WIDTH'(1)) begin
              state_q <= S_LAST;
            end else if (total_zeros == '0) begin
              state_q <= S_EMIT_ZERO;
            end else begin
              state_q <= S_READ;
            end
          end
        end

        S_READ: begin
          if (!fifo_empty) begin
            if (dec_illegal) begin
              // Abort: report at once and stop reading; the rest of the
              // block cannot be trusted.
              error_q  <= 1'b1;
              finish_q <= 1'b1;
              busy_q   <= 1'b0;
              code_q   <= '0;
              len_q    <= '0;
              state_q  <= S_IDLE;
            end else if (dec_hit) begin
              run_valid_q  <= 1'b1;
              run_before_q <= run_ext;
              run_idx_q    <= idx_q;
              zeros_left_q <= zl_after;
              remaining_q  <= rem_after;
              idx_q        <= idx_q + NZQ_WIDTH'(1);
              code_q       <= '0;
              len_q        <= '0;
              if (rem_after == NZQ_WIDTH'(1)) begin
                state_q <= S_LAST;
              end else if (zl_after == '0) begin
                state_q <= S_EMIT_ZERO;
              end
            end else begin
              code_q <= code_d;
              len_q  <= len_d;
            end
          end
        end

        S_EMIT_ZERO: begin
          run_valid_q  <= 1'b1;
          run_before_q <= '0;
          run_idx_q    <= idx_q;
          remaining_q  <= rem_after;
          idx_q        <= idx_q + NZQ_WIDTH'(1);
          if (rem_after == NZQ_WIDTH'(1)) begin
            state_q <= S_LAST;
          end
        end

        S_LAST: begin
          // The final coefficient absorbs every zero still unaccounted for.
          run_valid_q  <= 1'b1;
          run_before_q <= zeros_left_q;
          run_idx_q    <= idx_q;
          zeros_left_q <= '0;
          remaining_q  <= rem_after;
          idx_q        <= idx_q + NZQ_WIDTH'(1);
          state_q      <= S_DONE;
        end

        S_DONE: begin
          finish_q <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= S_IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_run_before_decoder.sv
// ---------------------------------------------------------------------------
// Testbench for run_before_decoder. A single process drives the block, plays
// the FIFO and records outputs on the falling edge. Expected runs come from
// a reference decoder that walks the code tables entry by entry.
// ---------------------------------------------------------------------------
module tb_run_before_decoder;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [4:0] NZQ;
  logic [3:0] total_zeros;
  logic       fifo_data  = 1'b0;
  logic       fifo_empty = 1'b1;
  logic       fifo_pop;
  logic [3:0] run_before;
  logic [4:0] run_idx;
  logic       run_valid;
  logic       busy;
  logic       finish;
  logic       error;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  run_before_decoder #(.NZQ_WIDTH(5), .ZL_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .NZQ(NZQ), .total_zeros(total_zeros),
    .fifo_data(fifo_data), .fifo_empty(fifo_empty), .fifo_pop(fifo_pop),
    .run_before(run_before), .run_idx(run_idx), .run_valid(run_valid),
    .busy(busy), .finish(finish), .error(error), .dbg_state_o(dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- FIFO model and monitor state ----------------
  bit         fifo_q[$];
  bit         blk_bits[$];
  bit         stall_en = 1'b0;
  bit         pop_pending = 1'b0;
  int         cyc = 0;
  logic [3:0] obs_run_q[$];
  logic [4:0] obs_idx_q[$];
  int         obs_cyc_q[$];
  int         obs_pops, fin_cnt, err_cnt, err_solo, rv_with_err, fin_abs;

  // ---------------- scoreboard / reference model ----------------
  logic [3:0] exp_q[$];
  int         exp_pops;
  bit         exp_err;
  int         t_zl[$], t_len[$], t_code[$], t_run[$];

  task automatic add_code(input int zl, input int len, input int code, input int run);
    t_zl.push_back(zl); t_len.push_back(len); t_code.push_back(code); t_run.push_back(run);
  endtask

  task automatic init_tables();
    add_code(1,1,1,0); add_code(1,1,0,1);
    add_code(2,1,1,0); add_code(2,2,1,1); add_code(2,2,0,2);
    add_code(3,2,3,0); add_code(3,2,2,1); add_code(3,2,1,2); add_code(3,2,0,3);
    add_code(4,2,3,0); add_code(4,2,2,1); add_code(4,2,1,2); add_code(4,3,1,3); add_code(4,3,0,4);
    add_code(5,2,3,0); add_code(5,2,2,1); add_code(5,3,3,2); add_code(5,3,2,3);
    add_code(5,3,1,4); add_code(5,3,0,5);
    add_code(6,2,3,0); add_code(6,3,0,1); add_code(6,3,1,2); add_code(6,3,3,3);
    add_code(6,3,2,4); add_code(6,3,5,5); add_code(6,3,4,6);
    for (int r = 0; r <= 6; r++) add_code(7, 3, 7 - r, r);
    for (int k = 3; k <= 10; k++) add_code(7, k + 1, 1, 4 + k);
  endtask

  function automatic bit lookup(input int zl, input int len, input int code, output int run);
    run = 0;
    for (int i = 0; i < t_zl.size(); i++) begin
      if (t_zl[i] == zl && t_len[i] == len && t_code[i] == code) begin
        run = t_run[i];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  // Decode one block from blk_bits into exp_q / exp_pops / exp_err.
  task automatic model_block(input int nzq, input int tz);
    int zl, rem, bi, code, len, run;
    bit found;
    exp_q.delete(); exp_pops = 0; exp_err = 1'b0; bi = 0; run = 0;
    if (nzq == 0) return;
    zl = tz; rem = nzq;
    while (rem > 1 && zl > 0 && !exp_err) begin
      code = 0; len = 0; found = 1'b0;
      while (!found && len < 11 && bi < blk_bits.size()) begin
        code = code * 2 + int'(blk_bits[bi]);
        bi++; exp_pops++; len++;
        found = lookup((zl > 7) ? 7 : zl, len, code, run);
      end
      if (!found || run > zl) exp_err = 1'b1;
      else begin
        exp_q.push_back(4'(run));
        zl -= run; rem--;
      end
    end
    if (!exp_err) begin
      while (rem > 1) begin exp_q.push_back(4'd0); rem--; end
      exp_q.push_back(4'(zl));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic load_bits(input bit b[$]);
    fifo_q = b;
    blk_bits = b;
    fifo_data  = (fifo_q.size() > 0) ? fifo_q[0] : 1'b0;
    fifo_empty = (fifo_q.size() == 0);
  endtask

  // One clock: apply the pop decided last cycle, refresh the FIFO head,
  // then sample outputs on the falling edge.
  task automatic cycle();
    @(posedge clk);
    #1;
    if (pop_pending && fifo_q.size() > 0) void'(fifo_q.pop_front());
    fifo_data  = (fifo_q.size() > 0) ? fifo_q[0] : 1'b0;
    fifo_empty = (fifo_q.size() == 0) || (stall_en && ($urandom_range(0, 2) == 0));
    @(negedge clk);
    cyc++;
    pop_pending = fifo_pop;
    if (rst) begin
      if (run_valid) begin
        obs_run_q.push_back(run_before);
        obs_idx_q.push_back(run_idx);
        obs_cyc_q.push_back(cyc);
      end
      if (fifo_pop) obs_pops++;
      if (finish) begin fin_cnt++; fin_abs = cyc; end
      if (error) err_cnt++;
      if (error && !finish) err_solo++;
      if (error && run_valid) rv_with_err++;
    end
  endtask

  task automatic clear_obs();
    obs_run_q.delete(); obs_idx_q.delete(); obs_cyc_q.delete();
    obs_pops = 0; fin_cnt = 0; err_cnt = 0; err_solo = 0; rv_with_err = 0; fin_abs = 0;
  endtask

  // Runs one block from a falling edge; restart_at > 0 re-pulses start
  // (NZQ=1) at that cycle of the block.
  task automatic run_block(input int nzq, input int tz, input int restart_at,
                           output bit timed_out, output int fin_cycle, output bit busy_at1);
    clear_obs();
    timed_out = 1'b1; fin_cycle = 0; busy_at1 = 1'b0;
    NZQ = nzq[4:0]; total_zeros = tz[3:0]; start = 1'b1;
    for (int n = 1; n <= 3000; n++) begin
      cycle();
      if (n == 1) begin start = 1'b0; busy_at1 = busy; end
      if (n == restart_at) begin start = 1'b1; NZQ = 5'd1; total_zeros = 4'd3; end
      else if (n == restart_at + 1) start = 1'b0;
      if (finish) begin fin_cycle = n; timed_out = 1'b0; break; end
    end
    start = 1'b0;
    repeat (3) cycle();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0; start = 1'b0; NZQ = '0; total_zeros = '0;
    repeat (3) cycle();
    checks++; if (fifo_pop !== 1'b0) begin errors++; $display("FAIL reset_fifo_pop: got %b expected 0", fifo_pop); end
    checks++; if (run_valid !== 1'b0) begin errors++; $display("FAIL reset_run_valid: got %b expected 0", run_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (finish !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL reset_finish_error: got %b%b expected 00", finish, error); end
    checks++; if (run_before !== 4'd0 || run_idx !== 5'd0) begin errors++; $display("FAIL reset_run_regs: got %0d/%0d expected 0/0", run_before, run_idx); end
    checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    rst = 1'b1;
    cycle();
  endtask

  task automatic test_basic_read();
    bit to, b1; int fc;
    load_bits('{1,0,1,0,1,1, 1,1,1,1});
    run_block(5, 3, 0, to, fc, b1);
    exp_q = '{4'd1, 4'd0, 4'd1, 4'd0, 4'd1};
    checks++; if (to) begin errors++; $display("FAIL basic_timeout: got no finish expected finish"); end
    checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", b1); end
    checks++; if (obs_pops != 6) begin errors++; $display("FAIL basic_pops: got %0d expected 6", obs_pops); end
    checks++; if (err_cnt != 0 || fin_cnt != 1) begin errors++; $display("FAIL basic_finish: got fin=%0d err=%0d expected fin=1 err=0", fin_cnt, err_cnt); end
    checks++;
    if (obs_run_q.size() != exp_q.size()) begin errors++; $display("FAIL basic_count: got %0d expected %0d", obs_run_q.size(), exp_q.size()); end
    else for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_run_q[i] !== exp_q[i] || obs_idx_q[i] !== 5'(i)) begin errors++; $display("FAIL basic_run%0d: got %0d@%0d expected %0d@%0d", i, obs_run_q[i], obs_idx_q[i], exp_q[i], i); end
    end
  endtask

  task automatic test_emit_zero();
    bit to, b1; int fc;
    load_bits('{});
    run_block(4, 0, 0, to, fc, b1);
    checks++; if (to || obs_pops != 0) begin errors++; $display("FAIL ez_pops: got to=%0d pops=%0d expected to=0 pops=0", to, obs_pops); end
    checks++;
    if (obs_run_q.size() != 4) begin errors++; $display("FAIL ez_count: got %0d expected 4", obs_run_q.size()); end
    else for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs_run_q[i] !== 4'd0 || obs_idx_q[i] !== 5'(i) || obs_cyc_q[i] != obs_cyc_q[0] + i)
        begin errors++; $display("FAIL ez_run%0d: got %0d@%0d cyc %0d expected 0@%0d cyc %0d", i, obs_run_q[i], obs_idx_q[i], obs_cyc_q[i], i, obs_cyc_q[0] + i); end
    end
    checks++; if (obs_cyc_q.size() == 4 && fin_abs != obs_cyc_q[3] + 1) begin errors++; $display("FAIL ez_finish: got cyc %0d expected %0d", fin_abs, obs_cyc_q[3] + 1); end
  endtask

  task automatic test_short_blocks();
    bit to, b1; int fc;
    load_bits('{});
    run_block(0, 0, 0, to, fc, b1);
    checks++; if (fc != 2 || to) begin errors++; $display("FAIL nzq0_latency: got %0d expected 2", fc); end
    checks++; if (obs_run_q.size() != 0) begin errors++; $display("FAIL nzq0_runs: got %0d expected 0", obs_run_q.size()); end
    load_bits('{1,1});
    run_block(1, 2, 0, to, fc, b1);
    checks++; if (obs_run_q.size() != 1 || obs_pops != 0) begin errors++; $display("FAIL nzq1_count: got %0d runs %0d pops expected 1 runs 0 pops", obs_run_q.size(), obs_pops); end
    else begin
      checks++; if (obs_run_q[0] !== 4'd2 || obs_idx_q[0] !== 5'd0) begin errors++; $display("FAIL nzq1_run: got %0d@%0d expected 2@0", obs_run_q[0], obs_idx_q[0]); end
    end
  endtask

  task automatic test_long_code();
    bit to, b1; int fc;
    load_bits('{0,0,0,0,0,0,0,0,0,0,1, 1,1,1});
    stall_en = 1'b1;
    run_block(2, 14, 0, to, fc, b1);
    stall_en = 1'b0;
    checks++; if (to || obs_pops != 11) begin errors++; $display("FAIL long_pops: got %0d expected 11", obs_pops); end
    checks++;
    if (obs_run_q.size() != 2) begin errors++; $display("FAIL long_count: got %0d expected 2", obs_run_q.size()); end
    else begin
      checks++; if (obs_run_q[0] !== 4'd14 || obs_run_q[1] !== 4'd0) begin errors++; $display("FAIL long_runs: got %0d,%0d expected 14,0", obs_run_q[0], obs_run_q[1]); end
    end
  endtask

  task automatic test_illegal();
    bit to, b1; int fc;
    load_bits('{0,0,0,0,0,0,0,0,0,0,0, 1,1,1,1});
    run_block(3, 8, 0, to, fc, b1);
    checks++; if (to || err_cnt != 1 || fin_cnt != 1) begin errors++; $display("FAIL illegal_flags: got err=%0d fin=%0d expected 1/1", err_cnt, fin_cnt); end
    checks++; if (err_solo != 0) begin errors++; $display("FAIL illegal_together: got %0d lone errors expected 0", err_solo); end
    checks++; if (obs_run_q.size() != 0) begin errors++; $display("FAIL illegal_runs: got %0d expected 0", obs_run_q.size()); end
    checks++; if (obs_pops != 11) begin errors++; $display("FAIL illegal_pops: got %0d expected 11", obs_pops); end
  endtask

  task automatic test_start_while_busy();
    bit to, b1; int fc;
    load_bits('{});
    run_block(4, 0, 1, to, fc, b1);
    checks++; if (to || obs_run_q.size() != 4 || fin_cnt != 1) begin errors++; $display("FAIL busy_start: got %0d runs %0d finishes expected 4 runs 1 finish", obs_run_q.size(), fin_cnt); end
  endtask

  task automatic test_reset_mid_read();
    bit to, b1; int fc;
    bit seen;
    load_bits('{1,1});
    run_block(2, 5, 0, to, fc, b1);
    checks++;
    if (obs_run_q.size() != 2) begin errors++; $display("FAIL pre_count: got %0d expected 2", obs_run_q.size()); end
    else if (obs_run_q[0] !== 4'd0 || obs_run_q[1] !== 4'd5) begin errors++; $display("FAIL pre_runs: got %0d,%0d expected 0,5", obs_run_q[0], obs_run_q[1]); end
    // Repeat the illegal block and pull reset while it is reading.
    load_bits('{0,0,0,0,0,0,0,0,0,0,0});
    clear_obs();
    NZQ = 5'd3; total_zeros = 4'd8; start = 1'b1;
    cycle();
    start = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 50; n++) begin
      if (obs_pops >= 3) begin seen = 1'b1; break; end
      cycle();
    end
    checks++; if (!seen || busy !== 1'b1) begin errors++; $display("FAIL mid_read_reached: got pops=%0d busy=%b expected pops>=3 busy=1", obs_pops, busy); end
    #2 rst = 1'b0;
    #1;
    checks++; if (fifo_pop !== 1'b0 || busy !== 1'b0 || dbg_state !== 3'd0) begin errors++; $display("FAIL async_rst_ctl: got pop=%b busy=%b state=%0d expected 0/0/0", fifo_pop, busy, dbg_state); end
    checks++; if (run_before !== 4'd0 || run_idx !== 5'd0 || run_valid !== 1'b0 || finish !== 1'b0 || error !== 1'b0)
      begin errors++; $display("FAIL async_rst_out: got run=%0d idx=%0d rv=%b fin=%b err=%b expected zeros", run_before, run_idx, run_valid, finish, error); end
    @(negedge clk);
    load_bits('{});
    pop_pending = 1'b0;
    rst = 1'b1;
    cycle();
    load_bits('{1,0,1,0,1,1});
    run_block(5, 3, 0, to, fc, b1);
    checks++; if (to || obs_run_q.size() != 5 || obs_pops != 6 || err_cnt != 0) begin errors++; $display("FAIL post_rst_block: got %0d runs %0d pops expected 5 runs 6 pops", obs_run_q.size(), obs_pops); end
  endtask

  task automatic test_random();
    bit to, b1; int fc, nzq, tz;
    bit b[$];
    for (int blk = 0; blk < 30; blk++) begin
      nzq = $urandom_range(0, 16);
      if ($urandom_range(0, 4) == 0) tz = $urandom_range(0, 15);
      else tz = (nzq == 0) ? 0 : $urandom_range(0, (16 - nzq > 15) ? 15 : 16 - nzq);
      b.delete();
      for (int i = 0; i < 200; i++) b.push_back(($urandom_range(0, 99) < 40) ? 1'b1 : 1'b0);
      load_bits(b);
      model_block(nzq, tz);
      stall_en = ($urandom_range(0, 1) == 1);
      run_block(nzq, tz, 0, to, fc, b1);
      stall_en = 1'b0;
      checks++; if (to || fin_cnt != 1) begin errors++; $display("FAIL rnd%0d_finish: got to=%0d fin=%0d expected 0/1", blk, to, fin_cnt); end
      checks++; if (err_cnt != int'(exp_err) || err_solo != 0 || rv_with_err != 0)
        begin errors++; $display("FAIL rnd%0d_error: got %0d (lone %0d) expected %0d", blk, err_cnt, err_solo, exp_err); end
      checks++; if (obs_pops != exp_pops) begin errors++; $display("FAIL rnd%0d_pops: got %0d expected %0d", blk, obs_pops, exp_pops); end
      checks++;
      if (obs_run_q.size() != exp_q.size()) begin errors++; $display("FAIL rnd%0d_count: got %0d expected %0d (nzq %0d tz %0d)", blk, obs_run_q.size(), exp_q.size(), nzq, tz); end
      else for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_run_q[i] !== exp_q[i] || obs_idx_q[i] !== 5'(i)) begin errors++; $display("FAIL rnd%0d_run%0d: got %0d@%0d expected %0d@%0d", blk, i, obs_run_q[i], obs_idx_q[i], exp_q[i], i); end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    init_tables();
    test_reset();
    test_basic_read();
    test_emit_zero();
    test_short_blocks();
    test_long_code();
    test_illegal();
    test_start_while_busy();
    test_reset_mid_read();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1);
  end

endmodule
